// File: rtl/mbscore_int_pending.sv
// Interrupt request front-end: synchronises raw lines, latches pending sources,
// and hands a frozen request vector to the controller until the handler returns.
module mbscore_int_pending #(
   parameter int unsigned      N_SRC       = 7,
   parameter int unsigned      SYNC_STAGES = 2,
   parameter logic [N_SRC-1:0] SYNC_MASK   = 7'b0111111
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SRC-1:0] irq_in,
   input  logic [N_SRC-1:0] edge_sel,
   input  logic             mask_wr,
   input  logic [N_SRC-1:0] mask_wdata,
   input  logic             ie_wr,
   input  logic             ie_wdata,
   input  logic             int_jump,
   input  logic             eret,
   output logic [N_SRC-1:0] int_vec,
   output logic             int_en_n,
   output logic [N_SRC-1:0] pending_q,
   output logic [N_SRC-1:0] mask_q,
   output logic             in_service
);

   typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

   state_t           state_q, state_d;
   logic [N_SRC-1:0] sync_q [SYNC_STAGES];
   logic [N_SRC-1:0] s, s_prev, set_vec, clear_vec, pending_d, vec_d;
   logic             ie_q, serv_d;

   // Only asynchronous bits enter the chain; synchronous bits bypass it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= irq_in & SYNC_MASK;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign s       = (sync_q[SYNC_STAGES-1] & SYNC_MASK) | (irq_in & ~SYNC_MASK);
   assign set_vec = (edge_sel & s & ~s_prev) | (~edge_sel & s);

   always_comb begin
      state_d   = state_q;
      vec_d     = int_vec;
      serv_d    = in_service;
      clear_vec = '0;
      case (state_q)
         IDLE: begin
            vec_d = '0;
            if (ie_q && (|(pending_q & mask_q))) begin
               vec_d   = pending_q & mask_q;
               state_d = REQ;
            end
         end
         REQ: begin
            if (int_jump) begin
               // isolate the lowest set bit = highest-priority requested source
               clear_vec = int_vec & (~int_vec + N_SRC'(1));
               vec_d     = '0;
               serv_d    = 1'b1;
               state_d   = SERV;
            end else if (ie_wr && !ie_wdata) begin
               vec_d   = '0;
               state_d = IDLE;
            end
         end
         SERV: begin
            vec_d = '0;
            if (eret) begin
               serv_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            vec_d   = '0;
            serv_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
      pending_d = (pending_q & ~clear_vec) | set_vec;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_prev     <= '0;
         pending_q  <= '0;
         mask_q     <= '0;
         ie_q       <= 1'b0;
         int_vec    <= '0;
         in_service <= 1'b0;
      end else begin
         s_prev     <= s;
         pending_q  <= pending_d;
         int_vec    <= vec_d;
         in_service <= serv_d;
         if (mask_wr) mask_q <= mask_wdata;
         if (ie_wr)   ie_q   <= ie_wdata;
      end
   end

   assign int_en_n = ~ie_q | in_service;

endmodule

// File: doc/mbscore_int_pending.md
Name: mbscore_int_pending

Overview:
- Interrupt request front-end for the MBScore interrupt controller.
- Takes raw device and syscall interrupt lines and synchronises the asynchronous ones.
- Detects edges or levels per source, holds pending bits, and applies the mask register and the global enable.
- Presents a frozen `int_vec` / `int_en_n` pair to the interrupt controller, retires the serviced source on `int_jump`, and blocks nesting until `eret`.

Parameters:
- N_SRC, 7, number of interrupt sources (matches `INT_SEL_WIDTH`). Bit 0 has the highest priority, bit N_SRC-1 the lowest. Bit indices equal the `INT_*` constants.
- SYNC_STAGES, 2, synchroniser depth for asynchronous sources. Legal range 2..3.
- SYNC_MASK, 7'b0111111, per-bit select: 1 = source is asynchronous and goes through the synchroniser; 0 = source is already in the clk domain (syscall).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- irq_in  in  N_SRC  raw interrupt lines
- edge_sel  in  N_SRC  per-source mode, static configuration: 1 = rising-edge, 0 = level
- mask_wr  in  1  write strobe for the mask register
- mask_wdata  in  N_SRC  new mask value (1 = source enabled)
- ie_wr  in  1  write strobe for the global enable
- ie_wdata  in  1  new global enable value
- int_jump  in  1  controller has taken the interrupt (acknowledge)
- eret  in  1  return from handler
- int_vec  out  N_SRC  registered request vector to the controller
- int_en_n  out  1  active-low enable to the controller
- pending_q  out  N_SRC  pending status register
- mask_q  out  N_SRC  mask register
- in_service  out  1  handler currently executing

Behaviour:
- Reset (async, rst=1), all registers cleared:
  - sync flops, edge-history flops, pending_q, mask_q, int_vec and the ie register = 0
  - state = IDLE, in_service = 0, int_en_n = 1
- Synchroniser: bits with SYNC_MASK=1 pass through a SYNC_STAGES flop chain. Bits with SYNC_MASK=0 are used directly. Call the result s.
- Pending set, per bit:
  - edge mode: set when s=1 and the previous-cycle s=0
  - level mode: set whenever s=1
  - pending_q updates on the clock edge.
- Pending clear: on accepted `int_jump`, clear the highest-priority (lowest-index) set bit of int_vec. If a set and a clear hit the same bit in the same cycle, set wins.
- Latency, with SYNC_STAGES=2 and irq_in rising before clock edge 0:
  - asynchronous bit: pending_q set after edge 2, int_vec valid after edge 3
  - synchronous bit: pending_q set after edge 0, int_vec valid after edge 1
- mask_wr / ie_wr take effect on the next clock edge and have no effect on pending_q.
- State machine:
  - IDLE: int_vec = 0. If ie=1 and (pending_q & mask_q) != 0: int_vec <= pending_q & mask_q, go to REQ.
  - REQ: int_vec is frozen; later pending or mask changes do not alter it.
    - `int_jump`: clear the target pending bit, int_vec <= 0, in_service <= 1, go to SERV.
    - ie_wr with ie_wdata=0 and no `int_jump` that cycle: int_vec <= 0, go to IDLE; pending bits are kept.
    - If `int_jump` and the ie clear arrive in the same cycle, `int_jump` wins.
  - SERV: int_vec = 0. `eret`: in_service <= 0, go to IDLE. A new request is evaluated in the cycle after returning to IDLE.
- int_en_n = ~ie | in_service, driven from registers with no combinational path from inputs.
- Ignored inputs:
  - `int_jump` outside REQ.
  - `eret` outside SERV.
  - `eret` and `int_jump` in the same cycle in REQ: `int_jump` is acted on, `eret` is ignored.
- Level source still asserted after its acknowledge: pending re-sets on the next edge and is served again after `eret`. This is intended.
- Reset mid-operation (any state): returns to IDLE with all registers cleared. Requests in flight are lost.

Test Plan:
1. Reset and masking:
   - Stimulus: assert rst; release; pulse irq_in[2] (edge mode) with mask_q=0, ie=1.
   - Required: pending_q=7'b0000100, int_vec stays 0. Then write mask 7'h7F → int_vec=7'b0000100 two edges after mask_wr.
2. Priority and retire:
   - Stimulus: mask=7'h7F, ie=1; raise irq_in[1] and irq_in[4] (edge mode) together.
   - Required: int_vec=7'b0010010. After `int_jump`: pending_q=7'b0010000, int_vec=0, in_service=1, int_en_n=1. After `eret`: int_vec=7'b0010000 on the second edge after `eret`.
3. Synchroniser latency:
   - Stimulus: SYNC_STAGES=2; raise irq_in[0] before edge 0.
   - Required: pending_q[0]=1 after edge 2, int_vec[0]=1 after edge 3. Syscall bit 6 raised before edge 0 → int_vec[6]=1 after edge 1.
4. Level source and set-wins:
   - Stimulus: irq_in[3] level mode, held high through `int_jump`.
   - Required: pending_q[3] reads 1 after the ack edge, and the source is re-served after `eret`. Edge source: new edge coincident with `int_jump` → pending bit stays 1.
5. Global disable in REQ:
   - Stimulus: in REQ, ie_wr=1 with ie_wdata=0.
   - Required: int_vec=0, int_en_n=1, state IDLE, pending_q unchanged. Re-enable → request reappears.
6. Reset mid-service:
   - Stimulus: assert rst while in SERV.
   - Required: immediately (asynchronously) in_service=0, int_vec=0, pending_q=0, mask_q=0, int_en_n=1.
